// File: rtl/simmem_release_scheduler_if.sv
// Request, release and acknowledge signals between the simulated-memory front end and the release scheduler.
// The scheduler sits on the slave modport; the traffic source and the message banks use master.
interface simmem_release_scheduler_if #(
  parameter int unsigned IDWidth    = 4,
  parameter int unsigned DelayWidth = 8
);
  // Request handshake: a request is taken on a rising edge where req_valid_i && req_ready_o.
  // The source may drop or change an untaken request at any time; req_ready_o never depends on req_valid_i.
  logic                                req_valid_i;
  logic                                req_ready_o;
  logic                                req_type_i;
  logic [IDWidth-1:0]                  req_id_i;
  logic [DelayWidth-1:0]               req_delay_i;
  logic [1:0][(1 << IDWidth)-1:0]      release_en_o;
  logic [1:0]                          released_valid_i;
  logic [1:0][IDWidth-1:0]             released_id_i;
  logic                                err_o;

  modport slave (
    input  req_valid_i, req_type_i, req_id_i, req_delay_i,
    input  released_valid_i, released_id_i,
    output req_ready_o, release_en_o, err_o
  );

  modport master (
    output req_valid_i, req_type_i, req_id_i, req_delay_i,
    output released_valid_i, released_id_i,
    input  req_ready_o, release_en_o, err_o
  );
endinterface

// File: rtl/simmem_release_scheduler.sv
// Delays read-data / write-response releases per AXI ID while preserving per-key order.
// Define SIMMEM_RELEASE_SCHEDULER_ERR_EN to build the sticky protocol-error flag on err_o.
module simmem_release_scheduler #(
  parameter int unsigned IDWidth    = 4,
  parameter int unsigned NumSlots   = 8,
  parameter int unsigned DelayWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  simmem_release_scheduler_if.slave bus
);
  localparam int unsigned NumIds    = 1 << IDWidth;
  localparam int unsigned RankWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int unsigned CountW    = $clog2(NumSlots + 1);

  logic [NumSlots-1:0]                 valid_q, valid_d;
  logic [NumSlots-1:0]                 type_q, type_d;
  logic [NumSlots-1:0][IDWidth-1:0]    id_q, id_d;
  logic [NumSlots-1:0][DelayWidth-1:0] cnt_q, cnt_d;
  logic [NumSlots-1:0][RankWidth-1:0]  rank_q, rank_d;

  logic [1:0][NumIds-1:0]   release_en;
  logic [1:0][NumSlots-1:0] ack_key;
  logic [1:0][NumSlots-1:0] ack_free;
  logic [1:0]               ack_hit;
  logic [NumSlots-1:0]      alloc_oh;
  logic                     alloc_found;
  logic                     req_ready;
  logic                     accept;
  logic [CountW-1:0]        same_cnt;
  logic                     freed_same;
  logic [RankWidth-1:0]     alloc_rank;

  // A slot is due when it is head of its key (rank 0) and its delay has run out.
  always_comb begin
    release_en = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (valid_q[s] && (rank_q[s] == '0) && (cnt_q[s] == '0)) begin
        release_en[type_q[s]][id_q[s]] = 1'b1;
      end
    end
  end

  always_comb begin
    ack_key  = '0;
    ack_free = '0;
    ack_hit  = '0;
    for (int t = 0; t < 2; t++) begin
      for (int s = 0; s < NumSlots; s++) begin
        if (bus.released_valid_i[t] && valid_q[s] && (type_q[s] == t[0]) &&
            (id_q[s] == bus.released_id_i[t])) begin
          ack_key[t][s] = 1'b1;
          if ((rank_q[s] == '0) && (cnt_q[s] == '0)) begin
            ack_free[t][s] = 1'b1;
          end
        end
      end
      ack_hit[t] = |ack_free[t];
    end
  end

  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    same_cnt    = '0;
    for (int s = 0; s < NumSlots; s++) begin
      if (!valid_q[s] && !alloc_found) begin
        alloc_oh[s] = 1'b1;
        alloc_found = 1'b1;
      end
      if (valid_q[s] && (type_q[s] == bus.req_type_i) && (id_q[s] == bus.req_id_i)) begin
        same_cnt = same_cnt + CountW'(1);
      end
    end
  end

  assign req_ready  = ~&valid_q;
  assign accept     = bus.req_valid_i & req_ready;
  // A same-key head leaving on this edge means the newcomer queues one place earlier.
  assign freed_same = ack_hit[bus.req_type_i] &&
                      (bus.released_id_i[bus.req_type_i] == bus.req_id_i);
  assign alloc_rank = RankWidth'(same_cnt - CountW'(freed_same));

  always_comb begin
    valid_d = valid_q;
    type_d  = type_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    rank_d  = rank_q;
    for (int s = 0; s < NumSlots; s++) begin
      if (valid_q[s] && (cnt_q[s] != '0)) begin
        cnt_d[s] = cnt_q[s] - DelayWidth'(1);
      end
      for (int t = 0; t < 2; t++) begin
        if (ack_hit[t] && ack_key[t][s]) begin
          if (ack_free[t][s]) begin
            valid_d[s] = 1'b0;
            cnt_d[s]   = '0;
            rank_d[s]  = '0;
          end else if (rank_q[s] != '0) begin
            rank_d[s] = rank_q[s] - RankWidth'(1);
          end
        end
      end
      // Allocation only targets an invalid slot, so it never collides with the updates above.
      if (accept && alloc_oh[s]) begin
        valid_d[s] = 1'b1;
        type_d[s]  = bus.req_type_i;
        id_d[s]    = bus.req_id_i;
        cnt_d[s]   = bus.req_delay_i;
        rank_d[s]  = alloc_rank;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      type_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      rank_q  <= '0;
    end else begin
      valid_q <= valid_d;
      type_q  <= type_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      rank_q  <= rank_d;
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.release_en_o = release_en;

`ifdef SIMMEM_RELEASE_SCHEDULER_ERR_EN
  localparam logic [CountW-1:0] MaxPending = CountW'((1 << RankWidth) - 1);

  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((bus.released_valid_i[0] && !ack_hit[0]) || (bus.released_valid_i[1] && !ack_hit[1])) begin
      err_d = 1'b1;
    end
    if (bus.req_valid_i && !req_ready && (same_cnt == MaxPending)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule
